divide_by4_decoder: RTL

- Receive-side partner of the JK-based 2-bit up/down divide-by-4 counter.
- Watches the counter's 2-bit phase output, recovers step direction, keeps a position count, and flags illegal phase jumps.
- Sits downstream of the counter in the same clock domain, or across a domain boundary when the synchroniser feature is built in.

---
 rtl/divide_by4_pkg.sv | 25 ++
 rtl/phase_sync2.sv | 25 ++
 rtl/divide_by4_decoder.sv | 132 +++++++++++++
 3 files changed

// File: rtl/divide_by4_pkg.sv
// Shared types and constants for the divide-by-4 phase decoder.
// The delta encoding is (new_phase - old_phase) mod 4 of a binary 2-bit count.
package divide_by4_pkg;

  typedef enum logic [1:0] {
    ARM   = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } dec_state_t;

  localparam logic [1:0] DELTA_NONE    = 2'd0;
  localparam logic [1:0] DELTA_UP      = 2'd1;
  localparam logic [1:0] DELTA_ILLEGAL = 2'd2;
  localparam logic [1:0] DELTA_DOWN    = 2'd3;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Modulo-4 phase difference; the 2-bit subtraction wraps naturally.
  function automatic logic [1:0] phase_delta(input logic [1:0] ph_new,
                                             input logic [1:0] ph_old);
    return ph_new - ph_old;
  endfunction

endpackage

// File: rtl/phase_sync2.sv
// Two-flop synchroniser for the 2-bit phase bus. Both stages reset to 0.
// The phase is a binary count that only ever moves by one step per source
// clock, so per-bit synchronisation can at worst show a transient illegal
// jump, which the decoder flags rather than hides.
module phase_sync2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] d,
  output logic [1:0] q
);

  logic [1:0] meta_q;

  // Two back-to-back capture stages.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 2'b00;
      q      <= 2'b00;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/divide_by4_decoder.sv
// Receive-side decoder for the 2-bit up/down divide-by-4 counter.
// Recovers step direction, keeps a wrapping position count, and flags
// phase jumps of two (illegal) into a sticky FAULT state left only via clr.
// Build option: define DIVBY4_DEC_SYNC_EN to place a 2-flop synchroniser
// on phase_in (adds 2 cycles of latency).
//
// state | meaning
// ARM   | absorb first phase sample after reset/clr, no pulses
// TRACK | decode steps, update position and direction
// FAULT | illegal jump seen; position frozen, errors still counted
module divide_by4_decoder
  import divide_by4_pkg::*;
#(
  parameter int POS_W = 16,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       phase_in,
  input  logic             clr,
  output logic             step_up,
  output logic             step_dn,
  output logic             dir,
  output logic [POS_W-1:0] position,
  output logic             pos_wrap,
  output logic             err_pulse,
  output logic             fault,
  output logic [ERR_W-1:0] err_count
);

  logic [1:0] ph;

`ifdef DIVBY4_DEC_SYNC_EN
  phase_sync2 u_phase_sync2 (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (phase_in),
    .q       (ph)
  );
`else
  assign ph = phase_in;
`endif

  dec_state_t       state_q, state_d;
  logic [1:0]       phase_q;
  logic [1:0]       delta;
  logic             up_d, dn_d, wrap_d, err_d, dir_d;
  logic [POS_W-1:0] pos_d;
  logic [ERR_W-1:0] errc_d;
  logic [ERR_W-1:0] errc_inc;

  assign delta    = phase_delta(ph, phase_q);
  assign errc_inc = (&err_count) ? err_count : err_count + 1'b1;

  // Next-state and next-output decode; clr wins over any coincident event.
  always_comb begin
    state_d = state_q;
    up_d    = 1'b0;
    dn_d    = 1'b0;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    dir_d   = dir;
    pos_d   = position;
    errc_d  = err_count;
    if (clr) begin
      pos_d   = '0;
      errc_d  = '0;
      state_d = ARM;
    end else begin
      case (state_q)
        ARM: state_d = TRACK;
        TRACK: begin
          case (delta)
            DELTA_UP: begin
              up_d   = 1'b1;
              dir_d  = DIR_UP;
              pos_d  = position + 1'b1;
              wrap_d = &position;
            end
            DELTA_DOWN: begin
              dn_d   = 1'b1;
              dir_d  = DIR_DOWN;
              pos_d  = position - 1'b1;
              wrap_d = ~|position;
            end
            DELTA_ILLEGAL: begin
              err_d   = 1'b1;
              errc_d  = errc_inc;
              state_d = FAULT;
            end
            default: ;
          endcase
        end
        FAULT: begin
          if (delta == DELTA_ILLEGAL) begin
            err_d  = 1'b1;
            errc_d = errc_inc;
          end
        end
        default: state_d = ARM;
      endcase
    end
  end

  // State, last-phase and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ARM;
      phase_q   <= 2'b00;
      step_up   <= 1'b0;
      step_dn   <= 1'b0;
      dir       <= DIR_UP;
      position  <= '0;
      pos_wrap  <= 1'b0;
      err_pulse <= 1'b0;
      fault     <= 1'b0;
      err_count <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= ph;
      step_up   <= up_d;
      step_dn   <= dn_d;
      dir       <= dir_d;
      position  <= pos_d;
      pos_wrap  <= wrap_d;
      err_pulse <= err_d;
      fault     <= (state_d == FAULT);
      err_count <= errc_d;
    end
  end

endmodule
